bin_to_bcd_seq: RTL and testbench

//   Sequential binary-to-BCD converter (shift-add-3 / double-dabble) that feeds the
//   16-bit data input of the 4-digit seven-segment display stage. Converts an unsigned

---
 rtl/bin_to_bcd_seq.sv | 95 +++++++++
 tb/tb_bin_to_bcd_seq.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble converter: turns an unsigned binary value into four packed
// BCD digits for the seven-segment stage, holding the last result between conversions.

module bcd_digit_adj (
    input  logic [3:0] din,
    output logic [3:0] dout
);
    assign dout = (din >= 4'd5) ? din + 4'd3 : din;
endmodule

module bin_to_bcd_seq #(
    parameter int BIN_W   = 14,
    parameter int MAX_VAL = 9999
) (
    input  logic             clk_50M,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] bin_in,
    output logic             busy,
    output logic             done,
    output logic             overflow,
    output logic [15:0]      data
);
    localparam int               NUM_DIG = 4;
    localparam int               CNT_W   = $clog2(BIN_W + 1);
    localparam logic [BIN_W-1:0] MAX_V   = BIN_W'(MAX_VAL);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t                        state, state_nxt;
    logic [BIN_W-1:0]              sh;
    logic [NUM_DIG-1:0][3:0]       acc, acc_adj;
    logic [CNT_W-1:0]              cnt;
    logic                          ovf_pend;
    logic                          over;
    logic                          last_shift;

    assign over       = bin_in > MAX_V;
    assign last_shift = cnt == CNT_W'(BIN_W - 1);

    // Every digit is corrected in parallel before the shift that would push it past 9
    for (genvar g = 0; g < NUM_DIG; g++) begin : g_dig
        bcd_digit_adj u_adj (.din(acc[g]), .dout(acc_adj[g]));
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = SHIFT;
            SHIFT:   if (last_shift) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_50M or negedge reset) begin
        if (!reset) begin
            sh       <= '0;
            acc      <= '0;
            cnt      <= '0;
            ovf_pend <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
            data     <= 16'h0000;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    sh       <= over ? MAX_V : bin_in;
                    acc      <= '0;
                    cnt      <= '0;
                    ovf_pend <= over;
                    busy     <= 1'b1;
                end
                SHIFT: begin
                    {acc, sh} <= {acc_adj, sh} << 1;
                    cnt       <= cnt + CNT_W'(1);
                end
                DONE: begin
                    data     <= acc;
                    overflow <= ovf_pend;
                    done     <= 1'b1;
                    busy     <= 1'b0;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed bench for bin_to_bcd_seq: vector table plus hand sequences for start-while-busy,
// back-to-back starts and reset mid-conversion.

module tb_bin_to_bcd_seq;
    localparam int BIN_W = 14;

    logic             clk_50M = 1'b0;
    logic             reset   = 1'b0;
    logic             start   = 1'b0;
    logic [BIN_W-1:0] bin_in  = '0;
    logic             busy, done, overflow;
    logic [15:0]      data;

    int checks = 0;
    int errors = 0;

    bin_to_bcd_seq #(.BIN_W(BIN_W), .MAX_VAL(9999)) dut (
        .clk_50M (clk_50M),
        .reset   (reset),
        .start   (start),
        .bin_in  (bin_in),
        .busy    (busy),
        .done    (done),
        .overflow(overflow),
        .data    (data)
    );

    always #10 clk_50M = ~clk_50M;

    typedef struct packed {
        logic [BIN_W-1:0] bin;
        logic [15:0]      exp_data;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Pulse start for one edge, then wait (bounded) for done; reports latency, busy cycles
    // and whether data/overflow stayed frozen until the done edge.
    task automatic convert(input logic [BIN_W-1:0] v, output int lat, output int busy_cnt,
                           output bit stable);
        logic [15:0] held;
        logic        held_ovf;
        held     = data;
        held_ovf = overflow;
        stable   = 1'b1;
        lat      = 0;
        @(negedge clk_50M);
        start  = 1'b1;
        bin_in = v;
        @(posedge clk_50M); #1;
        start    = 1'b0;
        bin_in   = ~v;
        busy_cnt = busy ? 1 : 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk_50M); #1;
            if (done) begin
                lat = n;
                break;
            end
            if (busy) busy_cnt++;
            if (data !== held || overflow !== held_ovf) stable = 1'b0;
        end
    endtask

    initial begin
        int  lat, bcnt, ndone, first_done, second_done;
        bit  stable;

        vecs[0]  = '{bin: 14'd0,     exp_data: 16'h0000, exp_ovf: 1'b0};
        vecs[1]  = '{bin: 14'd1234,  exp_data: 16'h1234, exp_ovf: 1'b0};
        vecs[2]  = '{bin: 14'd9999,  exp_data: 16'h9999, exp_ovf: 1'b0};
        vecs[3]  = '{bin: 14'd709,   exp_data: 16'h0709, exp_ovf: 1'b0};
        vecs[4]  = '{bin: 14'd12000, exp_data: 16'h9999, exp_ovf: 1'b1};
        vecs[5]  = '{bin: 14'd5,     exp_data: 16'h0005, exp_ovf: 1'b0};
        vecs[6]  = '{bin: 14'd10000, exp_data: 16'h9999, exp_ovf: 1'b1};
        vecs[7]  = '{bin: 14'd16383, exp_data: 16'h9999, exp_ovf: 1'b1};
        vecs[8]  = '{bin: 14'd255,   exp_data: 16'h0255, exp_ovf: 1'b0};
        vecs[9]  = '{bin: 14'd4096,  exp_data: 16'h4096, exp_ovf: 1'b0};
        vecs[10] = '{bin: 14'd8080,  exp_data: 16'h8080, exp_ovf: 1'b0};
        vecs[11] = '{bin: 14'd99,    exp_data: 16'h0099, exp_ovf: 1'b0};

        // Reset state and idle behaviour
        repeat (2) @(posedge clk_50M);
        #1;
        chk("rst_data", 32'(data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ovf",  32'(overflow), 32'h0);
        @(negedge clk_50M);
        reset = 1'b1;
        ndone = 0;
        for (int n = 0; n < 20; n++) begin
            @(posedge clk_50M); #1;
            if (done || busy) ndone++;
        end
        chk("idle_no_activity", 32'(ndone), 32'h0);
        chk("idle_data", 32'(data), 32'h0);

        for (int i = 0; i < 12; i++) begin
            convert(vecs[i].bin, lat, bcnt, stable);
            chk($sformatf("v%0d_latency", i), 32'(lat), 32'd15);
            chk($sformatf("v%0d_busy_cycles", i), 32'(bcnt), 32'd15);
            chk($sformatf("v%0d_busy_at_done", i), 32'(busy), 32'h0);
            chk($sformatf("v%0d_held_until_done", i), 32'(stable), 32'h1);
            chk($sformatf("v%0d_data", i), 32'(data), 32'(vecs[i].exp_data));
            chk($sformatf("v%0d_ovf", i), 32'(overflow), 32'(vecs[i].exp_ovf));
            @(posedge clk_50M); #1;
            chk($sformatf("v%0d_done_one_cycle", i), 32'(done), 32'h0);
        end

        // Start pulses with a different value while busy are ignored
        @(negedge clk_50M);
        start  = 1'b1;
        bin_in = 14'd42;
        @(posedge clk_50M); #1;
        start = 1'b0;
        ndone = 0;
        bcnt  = 1;
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk_50M);
            start  = (n < 10) && n[0];
            bin_in = 14'd77;
            @(posedge clk_50M); #1;
            if (done) ndone++;
            if (busy) bcnt++;
        end
        start = 1'b0;
        chk("busy_start_single_done", 32'(ndone), 32'd1);
        chk("busy_start_busy_cycles", 32'(bcnt), 32'd15);
        chk("busy_start_data", 32'(data), 32'h0042);

        // start held high: second conversion accepted on the edge after done
        @(negedge clk_50M);
        start       = 1'b1;
        bin_in      = 14'd56;
        first_done  = 0;
        second_done = 0;
        for (int n = 0; n <= 60; n++) begin
            @(posedge clk_50M); #1;
            if (done) begin
                if (first_done == 0) first_done = n;
                else begin
                    second_done = n;
                    start = 1'b0;
                    break;
                end
            end
        end
        start = 1'b0;
        chk("b2b_first_done", 32'(first_done), 32'd15);
        chk("b2b_gap", 32'(second_done - first_done), 32'd16);
        chk("b2b_data", 32'(data), 32'h0056);
        repeat (20) @(posedge clk_50M);
        #1;
        chk("b2b_idle_after", 32'(busy), 32'h0);

        // Reset during the 6th SHIFT cycle aborts the conversion
        convert(14'd1234, lat, bcnt, stable);
        chk("pre_rst_data", 32'(data), 32'h1234);
        @(negedge clk_50M);
        start  = 1'b1;
        bin_in = 14'd9999;
        @(posedge clk_50M); #1;
        start = 1'b0;
        repeat (5) @(posedge clk_50M);
        #1;
        chk("mid_busy", 32'(busy), 32'h1);
        reset = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data), 32'h0);
        chk("mid_rst_busy", 32'(busy), 32'h0);
        chk("mid_rst_done", 32'(done), 32'h0);
        @(negedge clk_50M);
        @(negedge clk_50M);
        reset = 1'b1;
        ndone = 0;
        for (int n = 0; n < 30; n++) begin
            @(posedge clk_50M); #1;
            if (done || busy) ndone++;
        end
        chk("post_rst_no_done", 32'(ndone), 32'h0);
        chk("post_rst_data", 32'(data), 32'h0);
        convert(14'd56, lat, bcnt, stable);
        chk("post_rst_latency", 32'(lat), 32'd15);
        chk("post_rst_conv", 32'(data), 32'h0056);
        chk("post_rst_ovf", 32'(overflow), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
